// File: rtl/ddr_rdata_gather.sv
// DDR read-data gather: waits CAS latency, packs PHY beats into AXI words and
// pushes {last, word} into the downstream read FIFO under credit flow control.
`timescale 1ns/1ps
module ddr_rdata_gather #(
   parameter int DQ_WIDTH       = 8,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int ADDR_WIDTH     = 10,
   parameter int LEN_WIDTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [LEN_WIDTH-1:0]      cmd_len,
   input  logic [3:0]                cmd_cl,
   input  logic [DQ_WIDTH-1:0]       dq_in,
   input  logic                      fifo_pop,
   output logic                      out_valid,
   output logic [AXI_DATA_WIDTH:0]   out_data,
   output logic                      busy
);
   localparam int BEATS = AXI_DATA_WIDTH / DQ_WIDTH;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] CRED_MAX = '1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_CL = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   logic [1:0]                state;
   logic [ADDR_WIDTH-1:0]     credits;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      word_cnt;
   logic [3:0]                lat_cnt;
   logic [BW-1:0]             beat_cnt;
   logic [AXI_DATA_WIDTH-1:0] word_nxt;
   logic [CW-1:0]             need;
   logic [CW-1:0]             have;
   logic [3:0]                cl_eff;
   logic                      accept;
   logic                      sample;
   logic                      word_done;
   logic                      last_word;
   logic                      pop_ok;

   // Both sides widened so a long burst never aliases against a small credit count.
   assign need      = CW'(cmd_len) + CW'(1);
   assign have      = CW'(credits);
   assign cmd_ready = (state == IDLE) && (have >= need);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);
   assign cl_eff    = (cmd_cl == 4'd0) ? 4'd1 : cmd_cl;

   // The edge that ends the latency wait is also the first sample edge.
   assign sample    = (state == CAPTURE) || ((state == WAIT_CL) && (lat_cnt == 4'd0));
   assign word_done = sample && (beat_cnt == BW'(BEATS - 1));
   assign last_word = (word_cnt == len_q);
   assign pop_ok    = fifo_pop && (credits != CRED_MAX);

   generate
      if (BEATS == 1) begin : g_single
         assign word_nxt = dq_in;
      end else begin : g_multi
         // Earlier beats enter at the top and drift down, so beat 0 ends in the LSBs.
         logic [(BEATS-1)*DQ_WIDTH-1:0] shreg;
         assign word_nxt = {dq_in, shreg};
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               shreg <= '0;
            else if (sample)
               shreg <= word_nxt[AXI_DATA_WIDTH-1:DQ_WIDTH];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         credits   <= CRED_MAX;
         len_q     <= '0;
         word_cnt  <= '0;
         lat_cnt   <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         credits   <= credits + ADDR_WIDTH'(pop_ok)
                      - (accept ? ADDR_WIDTH'(need) : ADDR_WIDTH'(0));

         case (state)
            IDLE: begin
               if (accept) begin
                  len_q    <= cmd_len;
                  lat_cnt  <= cl_eff - 4'd1;
                  word_cnt <= '0;
                  beat_cnt <= '0;
                  state    <= WAIT_CL;
               end
            end
            WAIT_CL: begin
               if (lat_cnt != 4'd0)
                  lat_cnt <= lat_cnt - 4'd1;
               else
                  state <= CAPTURE;
            end
            CAPTURE: ;
            default: state <= IDLE;
         endcase

         // Placed after the case so a final push out of WAIT_CL still lands in IDLE.
         if (sample) begin
            if (word_done) begin
               out_valid <= 1'b1;
               out_data  <= {last_word, word_nxt};
               beat_cnt  <= '0;
               word_cnt  <= word_cnt + 1'b1;
               if (last_word)
                  state <= IDLE;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ddr_rdata_gather.sv
// Bench for ddr_rdata_gather: credit/ready vector table, directed latency and
// reset sequences, and random bursts scored against an edge-indexed push model.
`timescale 1ns/1ps
module tb_ddr_rdata_gather;
   localparam int DQ   = 8;
   localparam int AW   = 16;
   localparam int ADDR = 10;
   localparam int LW   = 8;
   localparam int B    = AW / DQ;
   localparam int MAXC = (1 << ADDR) - 1;
   localparam int LOGN = 32768;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len = '0;
   logic [3:0]    cmd_cl = 4'd1;
   logic [DQ-1:0] dq_in = '0;
   logic          fifo_pop = 1'b0;
   logic          out_valid;
   logic [AW:0]   out_data;
   logic          busy;

   ddr_rdata_gather #(.DQ_WIDTH(DQ), .AXI_DATA_WIDTH(AW), .ADDR_WIDTH(ADDR), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_cl(cmd_cl), .dq_in(dq_in), .fifo_pop(fifo_pop), .out_valid(out_valid),
      .out_data(out_data), .busy(busy));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Edge log: dq_log[n] is the value present at rising edge n.
   int            edge_n = 0;
   logic [DQ-1:0] dq_log [LOGN];
   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      dq_log[edge_n % LOGN] <= dq_in;
   end

   // Reference model: each accepted burst becomes a list of push edges and beat ranges.
   typedef struct { int pe; int base; bit last; } push_t;
   push_t       exp_q[$];
   int          m_cred = MAXC;
   int          m_end = -1;
   logic [AW:0] m_last = '0;
   int          m_e, m_ce, m_len;
   bit          m_acc;

   initial forever begin
      @(posedge clk);
      if (!rst) begin
         m_e   = edge_n;
         m_len = int'(cmd_len);
         m_acc = cmd_valid && (m_e > m_end) && (m_cred >= m_len + 1);
         if (fifo_pop && m_cred != MAXC) m_cred++;
         if (m_acc) begin
            m_cred -= m_len + 1;
            m_ce = (cmd_cl == 4'd0) ? 1 : int'(cmd_cl);
            for (int k = 0; k <= m_len; k++)
               exp_q.push_back('{pe: m_e + m_ce + (k + 1) * B - 1, base: m_e + m_ce + k * B, last: (k == m_len)});
            m_end = m_e + m_ce + (m_len + 1) * B - 1;
         end
      end
   end

   // Scoreboard, sampled 1ns after every rising edge.
   bit          mon_v;
   logic [AW-1:0] mon_w;
   initial forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
         mon_v = (exp_q.size() > 0) && (exp_q[0].pe == edge_n - 1);
         chk("sb_out_valid", out_valid, mon_v);
         if (mon_v) begin
            for (int j = 0; j < B; j++)
               mon_w[j*DQ +: DQ] = dq_log[(exp_q[0].base + j) % LOGN];
            m_last = {exp_q[0].last, mon_w};
            void'(exp_q.pop_front());
         end
         chk("sb_out_data", out_data, m_last);
         chk("sb_busy", busy, edge_n <= m_end);
         chk("sb_credits", dut.credits, m_cred);
         chk("sb_cmd_ready", cmd_ready, (edge_n > m_end) && (m_cred >= int'(cmd_len) + 1));
      end
   end

   bit dq_rand = 1'b1;
   bit pop_rand = 1'b0;
   initial forever begin
      @(negedge clk);
      if (dq_rand)  dq_in = DQ'($urandom);
      if (pop_rand) fifo_pop = ($urandom_range(3) == 0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      fifo_pop = 1'b0;
      cmd_len = '0;
      exp_q.delete();
      m_cred = MAXC;
      m_end = -1;
      m_last = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_credits", dut.credits, MAXC);
      chk("rst_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      @(negedge clk);
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   // len=3 burst with dq = 0..7 on the sample edges; cl 0 and 1 must time identically.
   task automatic multi_burst(input logic [3:0] cl);
      logic [AW:0] x;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_len = 8'd3; cmd_cl = cl;
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         dq_in = DQ'(i - 1);
         @(posedge clk);
         #1;
         chk($sformatf("multi_cl%0d_valid_e%0d", cl, i), out_valid, (i % 2 == 0) && (i <= 8));
         if ((i % 2 == 0) && (i <= 8)) begin
            x = {(i == 8), DQ'(i - 1), DQ'(i - 2)};
            chk($sformatf("multi_cl%0d_data_e%0d", cl, i), out_data, x);
         end
      end
      wait_idle(100);
   endtask

   typedef struct { bit do_rst; bit v; bit p; int len; bit exp_rdy; int exp_cred; } vec_t;
   vec_t tbl [18];

   initial begin
      tbl[0]  = '{0, 1, 0, 255, 1, 767};
      tbl[1]  = '{0, 1, 0, 255, 1, 511};
      tbl[2]  = '{0, 1, 0, 255, 1, 255};
      tbl[3]  = '{0, 1, 0, 255, 0, 255};
      tbl[4]  = '{0, 0, 1, 255, 0, 256};
      tbl[5]  = '{0, 1, 0, 255, 1, 0};
      tbl[6]  = '{1, 0, 0, 0,   0, 0};
      tbl[7]  = '{0, 1, 0, 255, 1, 767};
      tbl[8]  = '{0, 1, 0, 255, 1, 511};
      tbl[9]  = '{0, 1, 0, 255, 1, 255};
      tbl[10] = '{0, 1, 0, 244, 1, 10};
      tbl[11] = '{0, 1, 1, 4,   1, 6};
      tbl[12] = '{0, 1, 0, 5,   1, 0};
      tbl[13] = '{0, 1, 0, 0,   0, 0};
      tbl[14] = '{0, 0, 1, 0,   0, 1};
      tbl[15] = '{0, 1, 0, 0,   1, 0};
      tbl[16] = '{1, 0, 0, 0,   0, 0};
      tbl[17] = '{0, 0, 1, 0,   1, MAXC};

      do_reset();

      // Single-word burst, cl=3.
      dq_rand = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_len = 8'd0; cmd_cl = 4'd3;
      @(posedge clk);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         dq_in = (i == 3) ? 8'h34 : (i == 4) ? 8'h12 : 8'hA5;
         @(posedge clk);
         #1;
         chk($sformatf("single_valid_e%0d", i), out_valid, i == 4);
         if (i == 4) begin
            chk("single_data", out_data, 17'h11234);
            chk("single_ready_after", cmd_ready, 1);
            chk("single_busy_after", busy, 0);
         end
      end

      multi_burst(4'd1);
      multi_burst(4'd0);

      // Reset between beat 0 and beat 1 of word 0.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_len = 8'd1; cmd_cl = 4'd1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      dq_in = 8'h5A;
      @(posedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("midrst_no_push_%0d", i), out_valid, 0);
      end

      // Credit / ready vectors.
      dq_rand = 1'b1;
      do_reset();
      foreach (tbl[i]) begin
         if (tbl[i].do_rst) begin
            do_reset();
         end else begin
            @(negedge clk);
            cmd_valid = tbl[i].v;
            fifo_pop = tbl[i].p;
            cmd_len = LW'(tbl[i].len);
            cmd_cl = 4'd1;
            #1;
            chk($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_credits", i), dut.credits, tbl[i].exp_cred);
            @(negedge clk);
            cmd_valid = 1'b0;
            fifo_pop = 1'b0;
            wait_idle(2000);
         end
      end

      // Random traffic: commands also fire while busy, pops arrive at random.
      do_reset();
      pop_rand = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(3) == 0);
         cmd_len = ($urandom_range(7) == 0) ? LW'($urandom_range(63)) : LW'($urandom_range(15));
         cmd_cl = 4'($urandom_range(15));
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      pop_rand = 1'b0;
      fifo_pop = 1'b0;
      wait_idle(500);
      repeat (3) @(negedge clk);
      chk("rand_all_pushed", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
